// File: rtl/ram2_ctrl_if.sv
// CPU-side request/ack ports and SRAM pin bundle for the RAM2 sequencer.
// slave = controller side, master = CPU pipeline plus SRAM device.
interface ram2_ctrl_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_inst;
  logic        if_ack;

  logic        mem_ce;
  logic        mem_we;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_data_i;
  logic [15:0] mem_data_o;
  logic        mem_ack;

  logic        stall_req;

  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  modport slave (
    input  if_req, if_addr, mem_ce, mem_we, mem_addr_i, mem_data_i, sram_dq_i,
    output if_inst, if_ack, mem_data_o, mem_ack, stall_req,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr, mem_ce, mem_we, mem_addr_i, mem_data_i, sram_dq_i,
    input  if_inst, if_ack, mem_data_o, mem_ack, stall_req,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/ram2_ctrl.sv
// Arbiter and strobe sequencer sharing one async SRAM between fetch and data ports.
// Read ack WAIT_CYCLES+2 cycles after grant, write ack WAIT_CYCLES+4; stall held while a request is unacked.
module ram2_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  ram2_ctrl_if.slave   bus
);

  localparam logic [2:0] WC      = 3'(WAIT_CYCLES);
  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_MEM = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ACK
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        owner;
  logic        last_mem;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] if_inst_q;
  logic [15:0] mem_data_q;
  logic        if_ack_q;
  logic        mem_ack_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        dq_oe_q;
  logic        grant_mem;

  // MEM wins unless it was also the last port served and fetch is waiting.
  assign grant_mem = bus.mem_ce & ~(bus.if_req & last_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      owner      <= OWN_IF;
      last_mem   <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      if_inst_q  <= 16'h0000;
      mem_data_q <= 16'h0000;
      if_ack_q   <= 1'b0;
      mem_ack_q  <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_ce || bus.if_req) begin
            owner   <= grant_mem ? OWN_MEM : OWN_IF;
            addr_q  <= grant_mem ? bus.mem_addr_i : bus.if_addr;
            wdata_q <= bus.mem_data_i;
            ce_n_q  <= 1'b0;
            if (grant_mem && bus.mem_we) begin
              state   <= WR_SETUP;
              dq_oe_q <= 1'b1;
            end else begin
              state  <= RD;
              cnt    <= 3'd0;
              oe_n_q <= 1'b0;
            end
          end
        end
        RD: begin
          if (cnt == WC) begin
            if (owner == OWN_MEM) begin
              mem_data_q <= bus.sram_dq_i;
              mem_ack_q  <= 1'b1;
            end else begin
              if_inst_q <= bus.sram_dq_i;
              if_ack_q  <= 1'b1;
            end
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            state  <= ACK;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR_SETUP: begin
          cnt    <= 3'd0;
          we_n_q <= 1'b0;
          state  <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == WC) begin
            we_n_q <= 1'b1;
            state  <= WR_HOLD;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR_HOLD: begin
          ce_n_q    <= 1'b1;
          dq_oe_q   <= 1'b0;
          mem_ack_q <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          last_mem <= (owner == OWN_MEM);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_inst    = if_inst_q;
  assign bus.if_ack     = if_ack_q;
  assign bus.mem_data_o = mem_data_q;
  assign bus.mem_ack    = mem_ack_q;
  assign bus.stall_req  = (bus.mem_ce & ~mem_ack_q) | (bus.if_req & ~if_ack_q);
  assign bus.sram_addr  = {2'b00, addr_q};
  assign bus.sram_dq_o  = wdata_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;

endmodule

// File: doc/ram2_ctrl.md
# ram2_ctrl

Sequencer and arbiter for the single-port external RAM2 SRAM, shared by the instruction-fetch port and the MEM-stage data port of the 16-bit CPU. It grants one requester at a time and generates SRAM control strobes with a programmable wait count. It returns instruction or read data over a request/ack handshake and raises a pipeline stall while any request is outstanding. It replaces the zero-latency simulation RAM model in the synthesizable top level.

## Interface
- WAIT_CYCLES, 1: extra cycles the read strobe and the write pulse are held (0..7).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  16  fetch word address
- if_inst  out  16  last fetched instruction, reset 16'h0000
- if_ack  out  1  one-cycle pulse: fetch complete, if_inst valid this cycle
- mem_ce  in  1  data access request, held until mem_ack
- mem_we  in  1  1 = write, 0 = read; sampled at grant
- mem_addr_i  in  16  data word address
- mem_data_i  in  16  write data
- mem_data_o  out  16  last data read, reset 16'h0000
- mem_ack  out  1  one-cycle pulse: data access complete
- stall_req  out  1  stall request to pipeline control
- sram_addr  out  18  SRAM address, {2'b00, granted addr}
- sram_dq_o  out  16  SRAM write data
- sram_dq_oe  out  1  tristate enable for sram_dq_o
- sram_dq_i  in  16  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK. A 3-bit counter `cnt` sequences RD and WR_PULSE. A 1-bit `owner` records the granted port (IF/MEM). A 1-bit `last_mem` records whether the previous completed access was MEM.
- Arbitration happens in IDLE only.
  - If mem_ce and if_req are both high and last_mem=1, grant IF.
  - Otherwise mem_ce has priority over if_req.
  - On grant, latch addr, we and wdata into registers. Inputs are not used again until the next grant.
- IDLE: ce_n=1, oe_n=1, we_n=1, dq_oe=0.
  - Grant MEM write → WR_SETUP.
  - Grant MEM read or IF → RD, cnt=0.
- RD: ce_n=0, oe_n=0. cnt increments each cycle. When cnt==WAIT_CYCLES:
  - capture sram_dq_i into if_inst (owner IF) or mem_data_o (owner MEM);
  - → ACK.
- WR_SETUP: ce_n=0, dq_oe=1, we_n=1 → WR_PULSE with cnt=0.
- WR_PULSE: ce_n=0, dq_oe=1, we_n=0. When cnt==WAIT_CYCLES → WR_HOLD.
- WR_HOLD: ce_n=0, dq_oe=1, we_n=1 → ACK.
- ACK: all strobes inactive, dq_oe=0. Pulse if_ack or mem_ack per owner; set last_mem = (owner==MEM); → IDLE.
- if_inst and mem_data_o change only at a read capture of their own owner; otherwise they hold.
- stall_req = (mem_ce & ~mem_ack) | (if_req & ~if_ack). It is combinational from inputs and registered state.
- A request dropped mid-access does not abort: the access completes and the ack still pulses.

## Timing
- Request sampled high in IDLE at edge N.
  - Read: RD covers cycles N+1..N+1+WAIT_CYCLES; ack high during cycle N+2+WAIT_CYCLES (3 cycles for WAIT_CYCLES=1).
  - Write: ack high during cycle N+4+WAIT_CYCLES (5 cycles for WAIT_CYCLES=1).
- One cycle of IDLE separates consecutive accesses. Back-to-back read throughput is therefore 1 per WAIT_CYCLES+3 cycles.
- sram_addr and sram_dq_o are stable from the first non-IDLE cycle through the last non-ACK cycle. we_n is never low while addr or data could change.
- Reset at any edge:
  - next state IDLE;
  - strobes inactive, dq_oe=0;
  - acks 0, cnt 0, last_mem 0;
  - if_inst and mem_data_o 0.
  - An interrupted write may leave the SRAM location undefined; no ack is issued for it.
- Ack is never asserted in two consecutive cycles. if_ack and mem_ack are never high together.

## Test plan
- WAIT_CYCLES=1, SRAM model preloaded with word 0x0005 = 16'h6901; if_req with if_addr=0x0005 → if_ack 3 cycles later, if_inst=16'h6901, stall_req high for the 3 cycles before ack.
- mem_ce=1, mem_we=1, addr 0x1234, data 16'hBEEF → we_n low for exactly 2 cycles with sram_addr=18'h01234 and sram_dq_o=16'hBEEF stable one cycle either side; mem_ack at cycle 5. A following read of 0x1234 returns 16'hBEEF.
- if_req and mem_ce (read) raised in the same IDLE cycle → MEM is served first and mem_ack pulses. With mem_ce re-raised, IF is served next (last_mem rule), then MEM again.
- Continuous mem_ce held high plus a pending if_req → grants alternate MEM/IF with no starvation over 10 accesses.
- rst asserted during WR_PULSE → next cycle: we_n=1, ce_n=1, dq_oe=0, state IDLE, no mem_ack, outputs zeroed.
- WAIT_CYCLES=0 → read ack at 2 cycles, write ack at 4 cycles, we_n low for 1 cycle.
